// File: rtl/shift_ram_sweep.sv
// RAM-based delay line for the correlator front end. Each accepted sample is
// written to a circular buffer, and then the newest sweep_len samples are replayed, oldest first.
module shift_ram_sweep #(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [AW:0]   sweep_len,
  input  logic [DW-1:0] din,
  input  logic          sin,
  output logic [DW-1:0] dout,
  output logic          sout,
  output logic [DW-1:0] dshift,
  output logic          dshift_valid,
  output logic          dshift_first,
  output logic          dshift_last,
  output logic          busy,
  output logic          overrun
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_SWEEP} state_t;

  // A length of zero, or one beyond the buffer, means a full-buffer sweep.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
    if (len == '0 || len > DEPTH_L) return DEPTH_L;
    return len;
  endfunction

  state_t        state_q;
  logic [AW-1:0] faddr_q, wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          first_pend_q;
  logic [DW-1:0] dout_q, dshift_q;
  logic          sout_q, dshift_valid_q, dshift_first_q, dshift_last_q, overrun_q;

  logic [DW-1:0] mem [DEPTH];

  logic [AW:0]   len_d;
  logic          accept, issue, we;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rd_data;

  always_comb begin
    len_d   = clamp_len(sweep_len);
    accept  = (state_q == S_IDLE) && sin && !clr;
    issue   = (state_q == S_SWEEP) && !clr;
    we      = !rst && ((state_q == S_FLUSH) || accept);
    waddr   = (state_q == S_FLUSH) ? faddr_q : wptr_q;
    wdata   = (state_q == S_FLUSH) ? '0 : din;
    raddr   = (state_q == S_SWEEP) ? rptr_q : wptr_q;
    rd_data = mem[raddr];
  end

  // Storage array is never reset; FLUSH clears it functionally.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FLUSH;
      faddr_q        <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      cnt_q          <= '0;
      first_pend_q   <= 1'b0;
      dout_q         <= '0;
      sout_q         <= 1'b0;
      dshift_q       <= '0;
      dshift_valid_q <= 1'b0;
      dshift_first_q <= 1'b0;
      dshift_last_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      // Registered read port: both output words are captured from the same read.
      sout_q <= accept;
      if (accept) dout_q <= rd_data;
      dshift_valid_q <= issue;
      dshift_first_q <= issue && first_pend_q;
      dshift_last_q  <= issue && (cnt_q == (AW+1)'(1));
      dshift_q       <= issue ? rd_data : '0;

      if (clr)                              overrun_q <= 1'b0;
      else if (sin && state_q != S_IDLE)    overrun_q <= 1'b1;

      if (clr) begin
        state_q      <= S_FLUSH;
        faddr_q      <= '0;
        first_pend_q <= 1'b0;
      end else begin
        case (state_q)
          S_FLUSH: begin
            faddr_q <= faddr_q + AW'(1);
            if (faddr_q == AW'(DEPTH - 1)) begin
              state_q <= S_IDLE;
              wptr_q  <= '0;
            end
          end
          S_IDLE: begin
            if (sin) begin
              wptr_q       <= wptr_q + AW'(1);
              rptr_q       <= wptr_q + AW'(1) - len_d[AW-1:0];
              cnt_q        <= len_d;
              first_pend_q <= 1'b1;
              state_q      <= S_SWEEP;
            end
          end
          S_SWEEP: begin
            rptr_q       <= rptr_q + AW'(1);
            cnt_q        <= cnt_q - (AW+1)'(1);
            first_pend_q <= 1'b0;
            if (cnt_q == (AW+1)'(1)) state_q <= S_IDLE;
          end
          default: state_q <= S_FLUSH;
        endcase
      end
    end
  end

  assign dout         = dout_q;
  assign sout         = sout_q;
  assign dshift       = dshift_q;
  assign dshift_valid = dshift_valid_q;
  assign dshift_first = dshift_first_q;
  assign dshift_last  = dshift_last_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_shift_ram_sweep.sv
// Directed bench for shift_ram_sweep at DW=8, AW=3 (8-word buffer).
module tb_shift_ram_sweep;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] sweep_len = 4'd8;
  logic [7:0] din = 8'd0;
  logic       sin = 1'b0;
  logic [7:0] dout, dshift;
  logic       sout, dshift_valid, dshift_first, dshift_last, busy, overrun;

  shift_ram_sweep #(.DW(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .sweep_len(sweep_len), .din(din), .sin(sin),
    .dout(dout), .sout(sout), .dshift(dshift), .dshift_valid(dshift_valid),
    .dshift_first(dshift_first), .dshift_last(dshift_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] hist[$];

  typedef struct {
    logic [7:0] d;
    logic [3:0] len;
    logic [7:0] exp_dout;
    logic [7:0] exp_first;
    int         exp_n;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hist_flush();
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(8'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " dout"}, dout, 0);
    check({tag, " sout"}, sout, 0);
    check({tag, " dshift"}, dshift, 0);
    check({tag, " dshift_valid"}, dshift_valid, 0);
    check({tag, " dshift_first"}, dshift_first, 0);
    check({tag, " dshift_last"}, dshift_last, 0);
    check({tag, " overrun"}, overrun, 0);
  endtask

  task automatic wait_flush(input string tag);
    for (int i = 0; i < 8; i++) begin
      check({tag, " busy during flush"}, busy, 1);
      check({tag, " valid during flush"}, dshift_valid, 0);
      tick();
    end
    check({tag, " busy after flush"}, busy, 0);
  endtask

  // One sample followed by its sweep; optional early sin, clr or rst at sweep step.
  task automatic run_vec(input logic [7:0] d, input logic [3:0] len, input logic [7:0] exp_dout,
                         input logic [7:0] exp_first, input int exp_n,
                         input int early_at, input int clr_at, input int rst_at);
    check("busy before sample", busy, 0);
    din = d; sweep_len = len; sin = 1'b1;
    tick();
    sin = 1'b0;
    check("sout", sout, 1);
    check("dout", dout, exp_dout);
    check("valid at T+1", dshift_valid, 0);
    check("busy in sweep", busy, 1);
    hist.push_back(d);
    for (int e = 1; e <= exp_n; e++) begin
      if (e == early_at) begin sin = 1'b1; din = 8'h55; end
      if (e == clr_at) clr = 1'b1;
      if (e == rst_at) rst = 1'b1;
      tick();
      sin = 1'b0; clr = 1'b0; rst = 1'b0;
      if (e == clr_at) begin
        check("clr valid", dshift_valid, 0);
        check("clr last", dshift_last, 0);
        check("clr overrun", overrun, 0);
        check("clr busy", busy, 1);
        check("clr dout kept", dout, exp_dout);
        return;
      end
      if (e == rst_at) begin
        check_quiet("rst mid-sweep");
        check("rst busy", busy, 1);
        return;
      end
      check("sweep valid", dshift_valid, 1);
      check("sweep word", dshift, hist[hist.size() - exp_n + e - 1]);
      check("sweep first", dshift_first, (e == 1) ? 1 : 0);
      check("sweep last", dshift_last, (e == exp_n) ? 1 : 0);
      check("sout pulse", sout, 0);
      if (e == 1) check("first word", dshift, exp_first);
      if (e == exp_n) check("last word", dshift, d);
      if (early_at != 0 && e >= early_at) check("overrun set", overrun, 1);
    end
    check("busy after sweep", busy, 0);
    check("dout held", dout, exp_dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 1; k <= 7; k++) vecs[k-1] = '{8'(k), 4'd8, 8'd0, 8'd0, 8};
    vecs[7]  = '{8'd8,  4'd8,  8'd0, 8'd1,  8};
    vecs[8]  = '{8'd9,  4'd8,  8'd1, 8'd2,  8};
    vecs[9]  = '{8'd10, 4'd8,  8'd2, 8'd3,  8};
    vecs[10] = '{8'd11, 4'd8,  8'd3, 8'd4,  8};
    vecs[11] = '{8'd12, 4'd3,  8'd4, 8'd10, 3};
    vecs[12] = '{8'd13, 4'd0,  8'd5, 8'd6,  8};
    vecs[13] = '{8'd14, 4'd15, 8'd6, 8'd7,  8};
    vecs[14] = '{8'd15, 4'd1,  8'd7, 8'd15, 1};

    // Reset and power-up flush
    rst = 1'b1;
    tick(); tick();
    check_quiet("reset");
    check("reset busy", busy, 1);
    rst = 1'b0;
    wait_flush("power-up");
    check_quiet("after flush");
    hist_flush();

    foreach (vecs[i])
      run_vec(vecs[i].d, vecs[i].len, vecs[i].exp_dout, vecs[i].exp_first, vecs[i].exp_n, 0, 0, 0);

    // Early sample two cycles before the sweep ends is dropped
    run_vec(8'd16, 4'd8, 8'd8, 8'd9, 8, 7, 0, 0);
    run_vec(8'd17, 4'd8, 8'd9, 8'd10, 8, 0, 0, 0);
    check("overrun sticky", overrun, 1);

    // Clear mid-sweep, then a fresh sample sweeps zeros then itself
    run_vec(8'd18, 4'd8, 8'd10, 8'd11, 8, 0, 4, 0);
    wait_flush("clr");
    check("overrun cleared", overrun, 0);
    hist_flush();
    run_vec(8'hAA, 4'd8, 8'd0, 8'd0, 8, 0, 0, 0);
    check("overrun after clr", overrun, 0);

    // Reset mid-sweep restarts the flush with write pointer at zero
    run_vec(8'h33, 4'd8, 8'd0, 8'd0, 8, 0, 0, 3);
    wait_flush("rst");
    check_quiet("after rst flush");
    hist_flush();
    run_vec(8'h44, 4'd1, 8'd0, 8'h44, 1, 0, 0, 0);
    run_vec(8'h45, 4'd2, 8'd0, 8'h44, 2, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
